// File: rtl/mix_add_key.sv
// AES MixColumns followed by AddRoundKey, one column per cycle through a shared mixer.
// Optional macro LAST_ROUND_EN adds a last_round input that bypasses the mixer.
module mix_add_key (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] state_in,
  input  logic [127:0] key_in,
`ifdef LAST_ROUND_EN
  input  logic         last_round,
`endif
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] state_out
);

  typedef enum logic [1:0] {StIdle, StMix, StDone} st_e;

  st_e          st_q, st_d;
  logic [1:0]   col_q;
  logic [127:0] data_q, key_q, out_q;
  logic [6:0]   lsb;
  logic [31:0]  col_in, mixed, col_out;
`ifdef LAST_ROUND_EN
  logic         last_q;
`endif

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Row 0 sits in the top byte of the column word.
  function automatic logic [31:0] mix_bytes(input logic [31:0] c);
    logic [7:0] i0, i1, i2, i3;
    i0 = c[31:24];
    i1 = c[23:16];
    i2 = c[15:8];
    i3 = c[7:0];
    return {xt(i0) ^ xt(i1) ^ i1 ^ i2 ^ i3,
            i0 ^ xt(i1) ^ xt(i2) ^ i2 ^ i3,
            i0 ^ i1 ^ xt(i2) ^ xt(i3) ^ i3,
            xt(i0) ^ i0 ^ i1 ^ i2 ^ xt(i3)};
  endfunction

  // Column c occupies bits [(3-c)*32 +: 32].
  assign lsb    = {~col_q, 5'd0};
  assign col_in = data_q[lsb +: 32];

  always_comb begin
    mixed = mix_bytes(col_in);
`ifdef LAST_ROUND_EN
    if (last_q) mixed = col_in;
`endif
    col_out = mixed ^ key_q[lsb +: 32];
  end

  always_comb begin
    st_d      = st_q;
    in_ready  = (st_q == StIdle);
    out_valid = (st_q == StDone);
    case (st_q)
      StIdle:  if (in_valid) st_d = StMix;
      StMix:   if (col_q == 2'd3) st_d = StDone;
      StDone:  if (out_ready) st_d = StIdle;
      default: st_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st_q   <= StIdle;
      col_q  <= 2'd0;
      data_q <= '0;
      key_q  <= '0;
      out_q  <= '0;
`ifdef LAST_ROUND_EN
      last_q <= 1'b0;
`endif
    end else begin
      st_q <= st_d;
      if (st_q == StIdle && in_valid) begin
        data_q <= state_in;
        key_q  <= key_in;
        col_q  <= 2'd0;
`ifdef LAST_ROUND_EN
        last_q <= last_round;
`endif
      end
      if (st_q == StMix) begin
        out_q[lsb +: 32] <= col_out;
        col_q            <= col_q + 2'd1;
      end
    end
  end

  assign state_out = out_q;

endmodule

// File: tb/tb_mix_add_key.sv
// Randomized self-checking bench for mix_add_key against a GF(2^8) matrix reference model.
module tb_mix_add_key;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] state_in;
  logic [127:0] key_in;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] state_out;
`ifdef LAST_ROUND_EN
  logic         last_round;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  mix_add_key dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .state_in  (state_in),
    .key_in    (key_in),
`ifdef LAST_ROUND_EN
    .last_round(last_round),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .state_out (state_out)
  );

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
    logic [7:0] a, b, p;
    a = a_in;
    b = b_in;
    p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = a[7] ? ({a[6:0], 1'b0} ^ 8'h1b) : {a[6:0], 1'b0};
      b = b >> 1;
    end
    return p;
  endfunction

  // Reference: out[c][r] = sum_j M[r][j]*s[c][j] ^ k[c][r], M row r = rotate {2,3,1,1} by r.
  function automatic logic [127:0] model(input logic [127:0] s, input logic [127:0] k,
                                         input logic lr);
    logic [7:0]   sb [16];
    logic [7:0]   kb [16];
    logic [7:0]   acc;
    logic [127:0] t, res;
    for (int n = 0; n < 16; n++) begin
      t = s >> (8 * (15 - n));
      sb[n] = t[7:0];
      t = k >> (8 * (15 - n));
      kb[n] = t[7:0];
    end
    res = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        acc = 8'h00;
        if (lr) acc = sb[4 * c + r];
        else begin
          for (int j = 0; j < 4; j++) begin
            case ((j - r) & 3)
              0:       acc = acc ^ gmul(8'h02, sb[4 * c + j]);
              1:       acc = acc ^ gmul(8'h03, sb[4 * c + j]);
              default: acc = acc ^ sb[4 * c + j];
            endcase
          end
        end
        res = (res << 8) | 128'(acc ^ kb[4 * c + r]);
      end
    end
    return res;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Push one block, check latency and result, optionally stall the output for `stall` cycles.
  task automatic run_block(input logic [127:0] s, input logic [127:0] k, input logic lr,
                           input logic [127:0] exp, input int stall, input string tag);
    int guard;
    int lat;
    guard = 0;
    while (!in_ready && guard < 20) begin
      tick();
      guard++;
    end
    check({tag, "_ready"}, 128'(in_ready), 128'(1));
    state_in = s;
    key_in   = k;
`ifdef LAST_ROUND_EN
    last_round = lr;
`endif
    in_valid  = 1'b1;
    out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 20) begin
      tick();
      lat++;
    end
    check({tag, "_latency"}, 128'(lat), 128'(5));
    check({tag, "_result"}, state_out, exp);
    for (int i = 0; i < stall; i++) begin
      in_valid = i[0];
      state_in = ~s;
      key_in   = rand128();
      tick();
      check({tag, "_stall_valid"}, 128'(out_valid), 128'(1));
      check({tag, "_stall_data"}, state_out, exp);
      check({tag, "_stall_ready"}, 128'(in_ready), 128'(0));
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({tag, "_release_valid"}, 128'(out_valid), 128'(0));
    check({tag, "_release_ready"}, 128'(in_ready), 128'(1));
  endtask

  logic [127:0] app_s, app_k, app_o;
  logic [127:0] bs [6];
  logic [127:0] bk [6];
  logic [127:0] exp_q [$];
  logic [127:0] s, k;

  initial begin
    app_s = 128'hd4bf5d30e0b452aeb84111f11e2798e5;
    app_k = 128'ha0fafe1788542cb123a339392a6c7605;
    app_o = 128'ha49c7ff2689f352b6b5bea43026a5049;
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    state_in = '0;
    key_in = '0;
`ifdef LAST_ROUND_EN
    last_round = 1'b0;
`endif
    tick();
    tick();
    rst = 1'b0;
    check("reset_in_ready", 128'(in_ready), 128'(1));
    check("reset_out_valid", 128'(out_valid), 128'(0));
    check("reset_state_out", state_out, 128'h0);

    run_block(app_s, app_k, 1'b0, app_o, 0, "appb");
    run_block({16{8'h01}}, 128'h0, 1'b0, {16{8'h01}}, 0, "ones");
    k = rand128();
    run_block(128'h0, k, 1'b0, k, 0, "zero_state");
    s = rand128();
    k = rand128();
    run_block(s, k, 1'b0, model(s, k, 1'b0), 10, "stall");

    // Reset in the second MIX cycle discards the block.
    state_in = rand128();
    key_in   = rand128();
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_out_valid", 128'(out_valid), 128'(0));
    check("midrst_state_out", state_out, 128'h0);
    check("midrst_in_ready", 128'(in_ready), 128'(1));
    for (int i = 0; i < 6; i++) begin
      tick();
      check("midrst_no_output", 128'(out_valid), 128'(0));
    end

    // Reset wins over a simultaneous accept.
    rst = 1'b1;
    in_valid = 1'b1;
    tick();
    rst = 1'b0;
    in_valid = 1'b0;
    check("rst_priority_ready", 128'(in_ready), 128'(1));
    tick();
    check("rst_priority_ready2", 128'(in_ready), 128'(1));

    s = rand128();
    k = rand128();
    run_block(s, k, 1'b0, model(s, k, 1'b0), 0, "after_rst");

    for (int i = 0; i < 12; i++) begin
      s = rand128();
      k = rand128();
      run_block(s, k, 1'b0, model(s, k, 1'b0), int'($urandom_range(0, 3)), "rand");
    end

`ifdef LAST_ROUND_EN
    run_block(app_s, app_k, 1'b1, app_s ^ app_k, 0, "last_appb");
    run_block(app_s, app_k, 1'b0, app_o, 0, "notlast_appb");
    for (int i = 0; i < 4; i++) begin
      s = rand128();
      k = rand128();
      run_block(s, k, 1'b1, model(s, k, 1'b1), 0, "last_rand");
    end
    last_round = 1'b0;
`endif

    // Back-to-back stream with both handshakes held high.
    for (int i = 0; i < 6; i++) begin
      bs[i] = rand128();
      bk[i] = rand128();
    end
    begin
      int cyc, last_acc, idx, nout;
      logic acc_now;
      cyc = 0;
      last_acc = -1;
      idx = 0;
      nout = 0;
      state_in = bs[0];
      key_in = bk[0];
      in_valid = 1'b1;
      out_ready = 1'b1;
      while (nout < 6 && cyc < 200) begin
        acc_now = 1'b0;
        if (in_valid && in_ready) begin
          if (last_acc >= 0) check("b2b_spacing", 128'(cyc - last_acc), 128'(6));
          last_acc = cyc;
          exp_q.push_back(model(bs[idx], bk[idx], 1'b0));
          idx++;
          acc_now = 1'b1;
        end
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) check("b2b_extra_output", 128'(1), 128'(0));
          else check("b2b_data", state_out, exp_q.pop_front());
          nout++;
        end
        tick();
        cyc++;
        if (acc_now) begin
          if (idx < 6) begin
            state_in = bs[idx];
            key_in = bk[idx];
          end else begin
            in_valid = 1'b0;
          end
        end
      end
      check("b2b_outputs", 128'(nout), 128'(6));
      in_valid = 1'b0;
      out_ready = 1'b0;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mix_add_key.md
MIX_ADD_KEY -- requirements
Module: mix_add_key

Interface
REQ-001 SHALL have ports: clk  input  1  rising-edge clock for all state.
REQ-002 SHALL have: rst  input  1  synchronous active-high reset, sampled on clk rising edge.
REQ-003 SHALL have: in_valid  input  1  state_in/key_in valid; in_ready  output  1  block can accept.
REQ-004 SHALL have: state_in  input  128  post-ShiftRows AES state; key_in  input  128  round key.
REQ-005 SHALL have: out_valid  output  1  state_out valid; out_ready  input  1  consumer accepts.
REQ-006 SHALL have: state_out  output  128  MixColumns(state_in) XOR key_in, registered.
REQ-007 SHALL have last_round  input  1  (present only with LAST_ROUND_EN), sampled with in_valid.

Function
REQ-008 SHALL use FIPS-197 byte order: byte k = bits [127-8k -: 8]; column c = bytes 4c..4c+3, row r = byte 4c+r.
REQ-009 SHALL process one column per cycle through a single mix_bytes instance (i0..i3 = rows 0..3).
REQ-010 SHALL implement FSM states IDLE, MIX, DONE; reset state IDLE.
REQ-011 SHALL assert in_ready combinationally iff state == IDLE; accept = in_valid & in_ready.
REQ-012 On accept SHALL register state_in, key_in (and last_round), clear column counter to 0, go MIX.
REQ-013 In MIX, each cycle SHALL write column c of state_out = mix_bytes(column c) XOR key column c, then c <= c+1.
REQ-014 Column counter SHALL be 2 bits; after c==3 is written SHALL go DONE (no wrap into column 0).
REQ-015 Latency: accept at edge 0, columns written edges 1..4, out_valid high from edge 4 (visible cycle after).
REQ-016 In DONE SHALL hold out_valid=1 and state_out stable until out_valid & out_ready, then go IDLE.
REQ-017 out_valid SHALL be 0 in IDLE and MIX; state_out columns not yet written SHALL not be relied on.
REQ-018 Next accept SHALL occur no earlier than the cycle after output handshake; throughput one block per 6 cycles min.
REQ-019 in_valid while not in IDLE SHALL be ignored (no capture, no error).
REQ-020 out_ready SHALL have no effect outside DONE.

Reset
REQ-021 rst SHALL force: FSM IDLE, counter 0, out_valid 0, state_out 128'h0, captured regs 0.
REQ-022 rst during MIX or DONE SHALL discard the in-flight block; no out_valid for it.
REQ-023 rst SHALL take priority over accept and output handshake in the same cycle; in_ready is 1 the cycle after.

Configuration
REQ-024 Macro LAST_ROUND_EN SHALL, when defined, add port last_round; captured last_round=1 bypasses mix_bytes (column XOR key only), same latency.
REQ-025 Without LAST_ROUND_EN, port last_round SHALL not exist and MixColumns SHALL always apply.

Verification
REQ-026 FIPS-197 App.B round 1: state_in d4bf5d30e0b452aeb84111f11e2798e5, key_in a0fafe1788542cb123a339392a6c7605 -> state_out a49c7ff2689f352b6b5bea43026a5049, out_valid exactly 5 cycles after accept cycle.
REQ-027 state_in all 8'h01, key_in 0 -> state_out all 8'h01; state_in 0, key_in K -> state_out K.
REQ-028 out_ready held 0 for 10 cycles in DONE -> out_valid and state_out stable, in_ready 0; in_valid pulses ignored.
REQ-029 rst asserted in MIX cycle 2 -> next cycle out_valid 0, state_out 0, in_ready 1; fresh vector then completes correctly.
REQ-030 LAST_ROUND_EN, last_round=1, App.B vector -> state_out = state_in XOR key_in; last_round=0 -> REQ-026 result.
REQ-031 Back-to-back: in_valid held high, out_ready high -> accepts spaced 6 cycles, outputs in order, none dropped.
